// File: rtl/cas_fsk_player.sv
// cas_fsk_player: regenerates CoCo FSK cassette audio from a CAS image in byte RAM, with gapless prefetch, pause, rewind, eot and position.
// Optional tape-sound monitor output enabled by defining CAS_MONITOR_EN.
module cas_fsk_player #(
   parameter int ADDR_W   = 16,
   parameter int MEM_LAT  = 2,
   parameter int HALF_DIV = 11932
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              rewind,
   input  logic [ADDR_W-1:0] tape_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              data,
   output logic              busy,
   output logic              eot,
   output logic [ADDR_W-1:0] pos
`ifdef CAS_MONITOR_EN
   ,
   output logic [15:0]       monitor
`endif
);
   localparam int CW = $clog2(2 * HALF_DIV);
   localparam logic [CW-1:0] ONE_END = CW'(HALF_DIV - 1);
   localparam logic [CW-1:0] ZERO_END = CW'(2 * HALF_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [ADDR_W:0] ONE_X = (ADDR_W + 1)'(1);
   typedef enum logic [1:0] {IDLE, FILL, SHIFT, EOT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic phase;
   logic [7:0] sreg, nbuf;
   logic nbuf_v, more;
   logic [MEM_LAT-1:0] rd_sh;
   logic rd_valid, start, load, half_end, byte_end, next_ok;
   logic [ADDR_W:0] pos1, pos2, len_x;
   always_comb begin
      len_x = {1'b0, tape_len};
      pos1 = {1'b0, pos} + ONE_X;
      pos2 = pos1 + ONE_X;
      next_ok = pos1 < len_x;
      rd_valid = rd_sh[MEM_LAT-1];
      start = state == IDLE && en;
      load = state == FILL && en && (rd_valid || nbuf_v);
      half_end = cnt == (sreg[0] ? ONE_END : ZERO_END);
      byte_end = state == SHIFT && en && half_end && phase && bit_idx == 3'd7;
      data = state == SHIFT && !phase;
      busy = state == SHIFT;
      eot = state == EOT;
      state_n = rewind ? IDLE :
                start ? (({1'b0, pos} >= len_x) ? EOT : FILL) :
                load ? SHIFT :
                byte_end ? (!next_ok ? EOT : nbuf_v ? SHIFT : IDLE) :
                state;
   end
   always_ff @(posedge clk) begin
      if (reset || rewind) begin
         state <= IDLE;
         pos <= '0;
         mem_addr <= '0;
         mem_rd <= 1'b0;
         cnt <= '0;
         bit_idx <= 3'd0;
         phase <= 1'b0;
         sreg <= 8'd0;
         nbuf <= 8'd0;
         nbuf_v <= 1'b0;
         more <= 1'b0;
         rd_sh <= '0;
      end else begin
         state <= state_n;
         mem_rd <= 1'b0;
         rd_sh <= MEM_LAT'({rd_sh, mem_rd});
         // reads land in the next buffer even while paused
         if (rd_valid && !load) begin
            nbuf <= mem_data;
            nbuf_v <= 1'b1;
         end
         if (start && state_n == FILL) begin
            mem_rd <= 1'b1;
            mem_addr <= pos;
            more <= pos1 < len_x;
         end
         if (load) begin
            sreg <= rd_valid ? mem_data : nbuf;
            nbuf_v <= 1'b0;
            cnt <= '0;
            phase <= 1'b0;
            bit_idx <= 3'd0;
            if (more) begin
               mem_rd <= 1'b1;
               mem_addr <= pos1[ADDR_W-1:0];
            end
         end
         if (state == SHIFT && en) begin
            if (!half_end) cnt <= cnt + CNT_ONE;
            else begin
               cnt <= '0;
               phase <= !phase;
               if (phase) begin
                  bit_idx <= bit_idx + 3'd1;
                  sreg <= {1'b0, sreg[7:1]};
               end
            end
         end
         // with no prefetched byte but more tape, fall back to IDLE to refetch
         if (byte_end) begin
            pos <= pos1[ADDR_W-1:0];
            if (next_ok && nbuf_v) begin
               sreg <= nbuf;
               nbuf_v <= 1'b0;
               if (pos2 < len_x) begin
                  mem_rd <= 1'b1;
                  mem_addr <= pos2[ADDR_W-1:0];
               end
            end
         end
      end
   end
`ifdef CAS_MONITOR_EN
   always_ff @(posedge clk) begin
      if (reset) monitor <= 16'h0000;
      else monitor <= (data && en) ? 16'h1000 : 16'h0000;
   end
`endif
endmodule
